gpu_compositor: RTL
===================

Name: gpu_compositor

Overview:
- Parametrised successor to the sprite-mux/palette stage of the GPU.
- Each pixel tick it does four things:
  - resolves N sprite layers by fixed priority, with a transparent index;
  - falls back to a background index when no sprite is opaque;
  - looks the winner up in an internal writable palette;
  - emits RGB888 with h_synch/v_synch/blank_n delayed to match, so colour and timing leave aligned.
- Sits between VGA_controller/sprite engines and the DAC pins.

Parameters:
- NBR_SPRITES, 8, number of sprite layers; 1..32.
- IDX_W, 8, palette index width; palette depth = 2**IDX_W.
- TRANSP_IDX, 0, sprite index value treated as transparent.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enb  in  1  pixel tick; pipeline advances only when high
- h_synch_in  in  1  horizontal sync from VGA_controller, active low
- v_synch_in  in  1  vertical sync from VGA_controller, active low
- blank_n_in  in  1  active-video flag from VGA_controller
- sprite_rden  in  NBR_SPRITES  per-sprite coverage of current pixel
- sprite_data  in  NBR_SPRITES*IDX_W  per-sprite palette index; sprite k at bits [k*IDX_W +: IDX_W]
- bg_index  in  IDX_W  background palette index
- pal_we  in  1  palette write strobe
- pal_addr  in  IDX_W  palette write address
- pal_wdata  in  24  palette write data {R,G,B}
- h_synch  out  1  delayed hsync
- v_synch  out  1  delayed vsync
- blank_n  out  1  delayed blank_n
- r_out  out  8  red
- g_out  out  8  green
- b_out  out  8  blue
- hit_id  out  $clog2(NBR_SPRITES) (min 1)  winning sprite number, aligned with RGB
- hit_valid  out  1  a sprite, not the background, supplied this pixel

Behaviour:
- Clocking and reset:
  - Single clock domain (clk); asynchronous active-low reset (rst_n).
- Reset values:
  - h_synch = 1, v_synch = 1, blank_n = 0.
  - RGB = 0, hit_id = 0, hit_valid = 0.
  - Palette contents are not reset.
  - Reset mid-frame drops all in-flight pixels; the first output after release comes 2 enb ticks later.
- Opacity:
  - Sprite k is opaque when sprite_rden[k] = 1 and its index != TRANSP_IDX.
- Priority:
  - The lowest-numbered opaque sprite wins.
  - With no opaque sprite: index = bg_index, hit_valid = 0, hit_id = 0.
  - bg_index is used even if it equals TRANSP_IDX.
- Pipeline (advances only on cycles with enb = 1; all state holds when enb = 0):
  - S1 registers: resolved index, hit_id, hit_valid, the three sync/blank inputs.
  - S2 registers: palette read (synchronous read of the S1 index), plus delayed sync/blank/hit.
  - Latency: exactly 2 enb ticks from inputs to all outputs, identical for colour and timing.
- Blanking:
  - If the S2 blank_n = 0, RGB is forced to 0.
  - hit_valid is forced to 0 and hit_id to 0.
- Palette:
  - 2**IDX_W x 24.
  - A write happens on any clk edge with pal_we = 1, independent of enb.
  - Write and read of the same address in the same cycle: the read returns the old data (read-before-write).
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: GPU_COMPOSITOR_COLLISION_EN.
- When defined, adds two outputs:
  - coll_mask[NBR_SPRITES]: bit k is set if sprite k was opaque on any active pixel where another sprite was also opaque.
  - coll_valid: one-cycle pulse when coll_mask is updated.
- Accumulation runs during the frame, only when blank_n_in = 1 and enb = 1.
- On the enb tick where v_synch_in falls (1→0):
  - the accumulator is copied to coll_mask;
  - coll_valid pulses high for one clk;
  - the accumulator clears.
- If a collision occurs on that same tick, it counts toward the new frame.
- coll_mask and coll_valid reset to 0.
- When the macro is undefined, the ports and logic are absent.

Decomposition:
- Shared package/define file holds:
  - NBR_SPRITES and IDX_W defaults;
  - the RGB888 field positions;
  - the sync idle level (1).
- Sub-module prio_resolver: combinational lowest-index-opaque select producing index, id and valid.
- Palette storage stays inline as an inferred RAM.

Test Plan:
- Reset and latency:
  - Release reset; palette[5] = 0xFF0000, bg_index = 5, blank_n_in = 1, enb = 1 every cycle.
  - Expect RGB = FF,00,00 and hit_valid = 0 on the 2nd tick.
  - Expect sync outputs to equal inputs delayed 2 ticks.
- Priority:
  - sprite_rden = 0b0110; sprite1 index 3, sprite2 index 7; palette[3] = 0x00FF00.
  - Expect hit_id = 1 and RGB = 00,FF,00.
  - Then set sprite1 index = TRANSP_IDX (0): expect hit_id = 2 and RGB = palette[7].
- Blanking and enb stall:
  - blank_n_in = 0 with an opaque sprite: expect RGB = 0 and hit_valid = 0 two ticks later.
  - Hold enb = 0 for 5 cycles: expect all outputs frozen; resume with no skipped or duplicated pixel.
- Palette write hazard:
  - pal_we to address 9 on the same cycle S1 holds index 9.
  - Expect the old colour on that pixel and the new colour on the next pixel using 9.
- Mid-frame reset:
  - Assert rst_n low during active video.
  - Expect outputs at reset values immediately (asynchronously).
  - After release, first valid RGB after 2 ticks.
- Collision (with GPU_COMPOSITOR_COLLISION_EN defined):
  - Sprites 0 and 3 both opaque on one active pixel, then a v_synch_in fall.
  - Expect coll_mask = 0x09 with a single coll_valid pulse.
  - The next frame with no overlap gives coll_mask = 0x00.

Source files
------------

// File: rtl/gpu_compositor_pkg.sv
// Shared definitions for the sprite compositor: default geometry, RGB888 layout
// and the idle level of the active-low sync lines.
package gpu_compositor_pkg;

    localparam int NBR_SPRITES_DEF = 8;
    localparam int IDX_W_DEF       = 8;

    localparam int RGB_W = 24;
    localparam int R_LSB = 16;
    localparam int G_LSB = 8;
    localparam int B_LSB = 0;

    localparam logic SYNC_IDLE = 1'b1;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // hit_id must stay at least one bit wide for a single-sprite build
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gpu_compositor_prio_resolver.sv
// Combinational sprite priority select: lowest-numbered opaque sprite wins,
// otherwise the background index is passed through with valid low.
module prio_resolver
    import gpu_compositor_pkg::*;
#(
    parameter int              NBR_SPRITES = NBR_SPRITES_DEF,
    parameter int              IDX_W       = IDX_W_DEF,
    parameter logic [IDX_W-1:0] TRANSP_IDX = '0
) (
    input  logic [NBR_SPRITES-1:0]       i_rden,
    input  logic [NBR_SPRITES*IDX_W-1:0] i_data,
    input  logic [IDX_W-1:0]             i_bg_index,
    output logic [IDX_W-1:0]             o_index,
    output logic [id_width(NBR_SPRITES)-1:0] o_id,
    output logic                         o_valid
);

    localparam int ID_W = id_width(NBR_SPRITES);

    always_comb begin
        o_index = i_bg_index;
        o_id    = '0;
        o_valid = 1'b0;
        for (int unsigned k = 0; k < NBR_SPRITES; k++) begin
            if (!o_valid && i_rden[k] && (i_data[k*IDX_W +: IDX_W] != TRANSP_IDX)) begin
                o_index = i_data[k*IDX_W +: IDX_W];
                o_id    = ID_W'(k);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpu_compositor.sv
// Sprite/background compositor with writable palette and 2-tick aligned timing.
// Optional collision reporting is enabled by defining GPU_COMPOSITOR_COLLISION_EN.
module gpu_compositor
    import gpu_compositor_pkg::*;
#(
    parameter int               NBR_SPRITES = NBR_SPRITES_DEF,
    parameter int               IDX_W       = IDX_W_DEF,
    parameter logic [IDX_W-1:0] TRANSP_IDX  = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enb,
    input  logic                         h_synch_in,
    input  logic                         v_synch_in,
    input  logic                         blank_n_in,
    input  logic [NBR_SPRITES-1:0]       sprite_rden,
    input  logic [NBR_SPRITES*IDX_W-1:0] sprite_data,
    input  logic [IDX_W-1:0]             bg_index,
    input  logic                         pal_we,
    input  logic [IDX_W-1:0]             pal_addr,
    input  logic [RGB_W-1:0]             pal_wdata,
    output logic                         h_synch,
    output logic                         v_synch,
    output logic                         blank_n,
    output logic [7:0]                   r_out,
    output logic [7:0]                   g_out,
    output logic [7:0]                   b_out,
    output logic [id_width(NBR_SPRITES)-1:0] hit_id,
    output logic                         hit_valid
`ifdef GPU_COMPOSITOR_COLLISION_EN
    ,
    output logic [NBR_SPRITES-1:0]       coll_mask,
    output logic                         coll_valid
`endif
);

    localparam int ID_W  = id_width(NBR_SPRITES);
    localparam int DEPTH = 2 ** IDX_W;

    logic [IDX_W-1:0] w_idx;
    logic [ID_W-1:0]  w_id;
    logic             w_valid;

    logic [IDX_W-1:0] r_s1_idx;
    logic [ID_W-1:0]  r_s1_id;
    logic             r_s1_valid;
    logic             r_s1_hs;
    logic             r_s1_vs;
    logic             r_s1_bn;

    logic [ID_W-1:0]  r_s2_id;
    logic             r_s2_valid;
    logic             r_s2_hs;
    logic             r_s2_vs;
    logic             r_s2_bn;

    rgb888_t          r_pal [DEPTH];
    rgb888_t          r_pal_q;
    logic [RGB_W-1:0] w_rgb;

    prio_resolver #(
        .NBR_SPRITES (NBR_SPRITES),
        .IDX_W       (IDX_W),
        .TRANSP_IDX  (TRANSP_IDX)
    ) u_prio (
        .i_rden     (sprite_rden),
        .i_data     (sprite_data),
        .i_bg_index (bg_index),
        .o_index    (w_idx),
        .o_id       (w_id),
        .o_valid    (w_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_idx   <= '0;
            r_s1_id    <= '0;
            r_s1_valid <= 1'b0;
            r_s1_hs    <= SYNC_IDLE;
            r_s1_vs    <= SYNC_IDLE;
            r_s1_bn    <= 1'b0;
            r_s2_id    <= '0;
            r_s2_valid <= 1'b0;
            r_s2_hs    <= SYNC_IDLE;
            r_s2_vs    <= SYNC_IDLE;
            r_s2_bn    <= 1'b0;
        end else if (enb) begin
            r_s1_idx   <= w_idx;
            r_s1_id    <= w_id;
            r_s1_valid <= w_valid;
            r_s1_hs    <= h_synch_in;
            r_s1_vs    <= v_synch_in;
            r_s1_bn    <= blank_n_in;
            r_s2_id    <= r_s1_id;
            r_s2_valid <= r_s1_valid;
            r_s2_hs    <= r_s1_hs;
            r_s2_vs    <= r_s1_vs;
            r_s2_bn    <= r_s1_bn;
        end
    end

    // Palette RAM: writes ignore enb; a same-edge read sees the pre-write word.
    always_ff @(posedge clk) begin
        if (pal_we) begin
            r_pal[pal_addr] <= pal_wdata;
        end
        if (enb) begin
            r_pal_q <= r_pal[r_s1_idx];
        end
    end

    // r_pal_q is not reset; the reset-cleared S2 blank flag masks it instead.
    assign w_rgb     = r_s2_bn ? r_pal_q : '0;
    assign r_out     = w_rgb[R_LSB +: 8];
    assign g_out     = w_rgb[G_LSB +: 8];
    assign b_out     = w_rgb[B_LSB +: 8];
    assign h_synch   = r_s2_hs;
    assign v_synch   = r_s2_vs;
    assign blank_n   = r_s2_bn;
    assign hit_id    = r_s2_bn ? r_s2_id : '0;
    assign hit_valid = r_s2_bn & r_s2_valid;

`ifdef GPU_COMPOSITOR_COLLISION_EN
    logic [NBR_SPRITES-1:0] w_opaque;
    logic                   w_coll;
    logic                   w_vs_fall;
    logic [NBR_SPRITES-1:0] r_coll_acc;
    logic [NBR_SPRITES-1:0] r_coll_mask;
    logic                   r_coll_valid;

    always_comb begin
        w_opaque = '0;
        for (int unsigned k = 0; k < NBR_SPRITES; k++) begin
            w_opaque[k] = sprite_rden[k] && (sprite_data[k*IDX_W +: IDX_W] != TRANSP_IDX);
        end
    end

    // More than one opaque bit set; r_s1_vs doubles as the previous-tick vsync.
    assign w_coll    = |(w_opaque & (w_opaque - NBR_SPRITES'(1)));
    assign w_vs_fall = enb & r_s1_vs & ~v_synch_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_coll_acc   <= '0;
            r_coll_mask  <= '0;
            r_coll_valid <= 1'b0;
        end else begin
            r_coll_valid <= w_vs_fall;
            if (w_vs_fall) begin
                r_coll_mask <= r_coll_acc;
                r_coll_acc  <= (blank_n_in && w_coll) ? w_opaque : '0;
            end else if (enb && blank_n_in && w_coll) begin
                r_coll_acc  <= r_coll_acc | w_opaque;
            end
        end
    end

    assign coll_mask  = r_coll_mask;
    assign coll_valid = r_coll_valid;
`endif

endmodule
